// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and the alignment rule for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Mask bit set means the lane is left untouched.
    localparam logic [3:0] MASK_NONE = 4'hf;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_WRITE,
        ST_WRITE_HOLD,
        ST_RESP
    } lsu_state_t;

    // High for a misaligned half/word or the reserved size code.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: access_error = 1'b0;
            SIZE_HALF: access_error = offset[0];
            SIZE_WORD: access_error = |offset;
            default:   access_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane steering for stores and extraction for loads
//
// Ports:
//   st_size, st_offset, st_data -> st_bus_data (lane-replicated), st_mask (1 = lane not written)
//   ld_size, ld_offset, ld_unsigned, ld_bus_data -> ld_result (extended load value)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [31:0] st_bus_data,
    output logic [3:0]  st_mask,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_bus_data,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_bus_data = st_data;
        st_mask     = MASK_NONE;
        case (st_size)
            SIZE_BYTE: begin
                st_bus_data = {4{st_data[7:0]}};
                st_mask     = ~(4'b0001 << st_offset);
            end
            SIZE_HALF: begin
                st_bus_data = {2{st_data[15:0]}};
                st_mask     = st_offset[1] ? 4'b0011 : 4'b1100;
            end
            SIZE_WORD: begin
                st_bus_data = st_data;
                st_mask     = 4'b0000;
            end
            default: begin
                st_bus_data = st_data;
                st_mask     = MASK_NONE;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_bus_data[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_bus_data[31:16] : ld_bus_data[15:0];
        case (ld_size)
            SIZE_BYTE: ld_result = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            SIZE_HALF: ld_result = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default:   ld_result = ld_bus_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding byte/half/word load/store bridge to memory_bus
//
// Ports:
//   clk, reset (sync, active low)
//   req_valid/req_ready/req_write/req_size/req_unsigned/req_address/req_data : CPU request
//   resp_valid/resp_data/resp_error : one-cycle completion
//   bus_address/bus_data_out/bus_data_in/bus_write_mask/bus_enable/bus_write_enable : memory_bus
//   load_count/store_count/error_count : only when LSU_STATS_EN is defined
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int WRITE_HOLD   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [15:0] req_address,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [15:0] bus_address,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    output logic [3:0]  bus_write_mask,
    output logic        bus_enable,
    output logic        bus_write_enable
`ifdef LSU_STATS_EN
    ,
    output logic [15:0] load_count,
    output logic [15:0] store_count,
    output logic [7:0]  error_count
`endif
);

    localparam logic [2:0] RL_CNT = 3'(READ_LATENCY);
    localparam logic [2:0] WH_CNT = 3'(WRITE_HOLD);

    lsu_state_t  state_q, state_d;
    logic        write_q, unsigned_q, error_q;
    logic [1:0]  size_q, offset_q;
    logic [2:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [3:0]  mask_q;
    logic [31:0] st_bus_data, ld_result;
    logic [3:0]  st_mask;
    logic        req_error;

    assign req_error = access_error(req_size, req_address[1:0]);

    lsu_lane_align u_align (
        .st_size     (req_size),
        .st_offset   (req_address[1:0]),
        .st_data     (req_data),
        .st_bus_data (st_bus_data),
        .st_mask     (st_mask),
        .ld_size     (size_q),
        .ld_offset   (offset_q),
        .ld_unsigned (unsigned_q),
        .ld_bus_data (bus_data_in),
        .ld_result   (ld_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_error)      state_d = ST_RESP;
                    else if (req_write) state_d = ST_WRITE;
                    else                state_d = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT:  if (cnt_q == 3'd1) state_d = ST_RESP;
            ST_WRITE:      state_d = (WH_CNT == 3'd0) ? ST_RESP : ST_WRITE_HOLD;
            ST_WRITE_HOLD: if (cnt_q == 3'd1) state_d = ST_RESP;
            ST_RESP:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            error_q      <= 1'b0;
            size_q       <= SIZE_BYTE;
            offset_q     <= 2'd0;
            cnt_q        <= 3'd0;
            rdata_q      <= 32'd0;
            mask_q       <= MASK_NONE;
            bus_address  <= 16'd0;
            bus_data_out <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        offset_q   <= req_address[1:0];
                        error_q    <= req_error;
                        rdata_q    <= 32'd0;
                        // Rejected requests leave every bus signal untouched.
                        if (!req_error) begin
                            bus_address <= {req_address[15:2], 2'b00};
                            if (req_write) begin
                                bus_data_out <= st_bus_data;
                                mask_q       <= st_mask;
                                cnt_q        <= WH_CNT;
                            end else begin
                                cnt_q <= RL_CNT;
                            end
                        end
                    end
                end
                // The counter would hit zero on this edge: the bus word is valid now.
                ST_READ_WAIT: begin
                    if (cnt_q == 3'd1) rdata_q <= ld_result;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                ST_WRITE_HOLD: begin
                    if (cnt_q != 3'd1) cnt_q <= cnt_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_count  <= 16'd0;
            store_count <= 16'd0;
            error_count <= 8'd0;
        end else if (state_q == ST_RESP) begin
            if (error_q) begin
                if (error_count != 8'hff) error_count <= error_count + 8'd1;
            end else if (write_q) begin
                if (store_count != 16'hffff) store_count <= store_count + 16'd1;
            end else begin
                if (load_count != 16'hffff) load_count <= load_count + 16'd1;
            end
        end
    end
`endif

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESP);
    assign resp_data        = resp_valid ? rdata_q : 32'd0;
    assign resp_error       = resp_valid & error_q;
    assign bus_enable       = (state_q == ST_READ_WAIT) || (state_q == ST_WRITE) ||
                              (state_q == ST_WRITE_HOLD);
    assign bus_write_enable = (state_q == ST_WRITE);
    assign bus_write_mask   = ((state_q == ST_WRITE) || (state_q == ST_WRITE_HOLD)) ?
                              mask_q : MASK_NONE;

endmodule
